// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory port.
// Optional retired_cnt field is present when MULTICYCLE_CTRL_PERF_EN is defined.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [1:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        reg_write;
    logic        pc_src;
    logic [1:0]  mem_to_reg;
    logic        illegal_instr;
    logic [3:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_cnt;
`endif

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, reg_write, pc_src,
               mem_to_reg, illegal_instr, state
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output retired_cnt
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, reg_write, pc_src,
               mem_to_reg, illegal_instr, state
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input retired_cnt
`endif
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multi-cycle RV32I core; MULTICYCLE_CTRL_PERF_EN adds retired_cnt.
// Latency: outputs decode combinationally from state; 2..5 cycles per instruction.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold with strobes asserted until mem_ready.
module multicycle_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    multicycle_ctrl_if.master ctrl
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_EXEC_I    = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q;
    state_t state_d;

    logic [1:0] alu_op_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] mem_to_reg_c;
    logic       iord_c;
    logic       pc_src_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       reg_write_c;
    logic       illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = S_FETCH;
        alu_op_c        = 2'b00;
        alu_src_a_c     = 2'b00;
        alu_src_b_c     = 2'b00;
        mem_to_reg_c    = 2'b00;
        iord_c          = 1'b0;
        pc_src_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        reg_write_c     = 1'b0;
        illegal_c       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                // IR and PC latch only on the cycle memory actually returns data
                ir_write_c  = ctrl.mem_ready;
                pc_write_c  = ctrl.mem_ready;
                state_d     = ctrl.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                case (ctrl.opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b00;
                alu_op_c    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b10;
                state_d     = (ctrl.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                state_d    = ctrl.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                state_d     = ctrl.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
                alu_src_a_c     = 2'b10;
                alu_src_b_c     = 2'b00;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_src_c        = 1'b1;
                state_d         = S_FETCH;
            end
            S_JAL: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b10;
                pc_write_c   = 1'b1;
                pc_src_c     = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Everything is gated by rst_n so an abort mid-access kills strobes immediately
    assign ctrl.mem_read      = rst_n & mem_read_c;
    assign ctrl.mem_write     = rst_n & mem_write_c;
    assign ctrl.ir_write      = rst_n & ir_write_c;
    assign ctrl.pc_write      = rst_n & pc_write_c;
    assign ctrl.pc_write_cond = rst_n & pc_write_cond_c;
    assign ctrl.reg_write     = rst_n & reg_write_c;
    assign ctrl.illegal_instr = rst_n & illegal_c;
    assign ctrl.iord          = rst_n & iord_c;
    assign ctrl.pc_src        = rst_n & pc_src_c;
    assign ctrl.alu_op        = rst_n ? alu_op_c     : 2'b00;
    assign ctrl.alu_src_a     = rst_n ? alu_src_a_c  : 2'b00;
    assign ctrl.alu_src_b     = rst_n ? alu_src_b_c  : 2'b00;
    assign ctrl.mem_to_reg    = rst_n ? mem_to_reg_c : 2'b00;
    assign ctrl.state         = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_q;
    logic        retire;

    // DECODE->FETCH is the illegal path and must not count
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                     (state_q == S_MEM_WRITE) || (state_q == S_BRANCH) ||
                     (state_q == S_JAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign ctrl.retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl; instruction-level reference model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0]  st;
        logic [1:0]  aop;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        iord;
        logic        mr;
        logic        mw;
        logic        irw;
        logic        pcw;
        logic        pcwc;
        logic        rw;
        logic        pcs;
        logic [1:0]  m2r;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    localparam logic Z = 1'b0;
    localparam logic O = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;
    logic [31:0] model_ret = 32'd0;
    exp_t exp_q[$];

    function automatic exp_t mk(input logic [3:0] st, input logic [1:0] aop,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic iord, input logic mr, input logic mw,
                                input logic irw, input logic pcw, input logic pcwc,
                                input logic rw, input logic pcs,
                                input logic [1:0] m2r, input logic ill);
        exp_t e;
        e = '{st, aop, sa, sb, iord, mr, mw, irw, pcw, pcwc, rw, pcs, m2r, ill, 32'd0};
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st   = bus.state;
        a.aop  = bus.alu_op;
        a.sa   = bus.alu_src_a;
        a.sb   = bus.alu_src_b;
        a.iord = bus.iord;
        a.mr   = bus.mem_read;
        a.mw   = bus.mem_write;
        a.irw  = bus.ir_write;
        a.pcw  = bus.pc_write;
        a.pcwc = bus.pc_write_cond;
        a.rw   = bus.reg_write;
        a.pcs  = bus.pc_src;
        a.m2r  = bus.mem_to_reg;
        a.ill  = bus.illegal_instr;
`ifdef MULTICYCLE_CTRL_PERF_EN
        a.ret  = bus.retired_cnt;
`else
        a.ret  = 32'd0;
`endif
        return a;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("cycle%0d", cyc_no), sample(), e);
        end
        cyc_no++;
    end

    // Called at posedge+1: drive inputs for this cycle and queue its expected outputs.
    task automatic cyc(input exp_t e, input logic [6:0] op, input logic rdy);
        bus.opcode    = op;
        bus.mem_ready = rdy;
`ifdef MULTICYCLE_CTRL_PERF_EN
        e.ret = model_ret;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
               (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1101111);
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] op;
        case ($urandom_range(0, 6))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            default: begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end
        endcase
        return op;
    endfunction

    task automatic fetch(input int wf);
        for (int i = 0; i < wf; i++)
            cyc(mk(4'd0, 2'b00, 2'b00, 2'b01, Z, O, Z, Z, Z, Z, Z, Z, 2'b00, Z), 7'($urandom), Z);
        cyc(mk(4'd0, 2'b00, 2'b00, 2'b01, Z, O, Z, O, O, Z, Z, Z, 2'b00, Z), 7'($urandom), O);
    endtask

    // Reference: instruction class -> sequence of phases (waits only in memory phases).
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
        logic r;
        fetch(wf);
        cyc(mk(4'd1, 2'b00, 2'b01, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, !is_legal(op)),
            op, 1'($urandom));
        if (!is_legal(op)) return;
        r = 1'($urandom);
        case (op)
            7'b0110011, 7'b0010011: begin
                if (op == 7'b0110011)
                    cyc(mk(4'd6, 2'b10, 2'b10, 2'b00, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, r);
                else
                    cyc(mk(4'd10, 2'b10, 2'b10, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, r);
                cyc(mk(4'd7, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, Z, Z, O, Z, 2'b00, Z), op, 1'($urandom));
            end
            7'b0000011: begin
                cyc(mk(4'd2, 2'b00, 2'b10, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, r);
                for (int i = 0; i < wm; i++)
                    cyc(mk(4'd3, 2'b00, 2'b00, 2'b00, O, O, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, Z);
                cyc(mk(4'd3, 2'b00, 2'b00, 2'b00, O, O, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, O);
                cyc(mk(4'd4, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, Z, Z, O, Z, 2'b01, Z), op, 1'($urandom));
            end
            7'b0100011: begin
                cyc(mk(4'd2, 2'b00, 2'b10, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), op, r);
                for (int i = 0; i < wm; i++)
                    cyc(mk(4'd5, 2'b00, 2'b00, 2'b00, O, Z, O, Z, Z, Z, Z, Z, 2'b00, Z), op, Z);
                cyc(mk(4'd5, 2'b00, 2'b00, 2'b00, O, Z, O, Z, Z, Z, Z, Z, 2'b00, Z), op, O);
            end
            7'b1100011:
                cyc(mk(4'd8, 2'b01, 2'b10, 2'b00, Z, Z, Z, Z, Z, O, Z, O, 2'b00, Z), op, r);
            default:
                cyc(mk(4'd9, 2'b00, 2'b00, 2'b00, Z, Z, Z, Z, O, Z, O, O, 2'b10, Z), op, r);
        endcase
        model_ret = model_ret + 32'd1;
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t zero;
        zero = '0;
        bus.opcode    = 7'b0110011;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", sample(), zero);
        rst_n = 1'b1;

        // Directed: R-type, load with 3 waits, branch, illegal, JAL, I-type
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b0000000, 0, 0);
        run_instr(7'b1101111, 1, 0);
        run_instr(7'b0010011, 2, 0);

        // Store aborted by reset while waiting in MEM_WRITE
        fetch(0);
        cyc(mk(4'd1, 2'b00, 2'b01, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), 7'b0100011, O);
        cyc(mk(4'd2, 2'b00, 2'b10, 2'b10, Z, Z, Z, Z, Z, Z, Z, Z, 2'b00, Z), 7'b0100011, O);
        cyc(mk(4'd5, 2'b00, 2'b00, 2'b00, O, Z, O, Z, Z, Z, Z, Z, 2'b00, Z), 7'b0100011, Z);
        #2;
        rst_n = 1'b0;
        #1;
        model_ret = 32'd0;
        chk("async_reset_abort", sample(), zero);
        @(posedge clk);
        #1;
        chk("reset_held", sample(), zero);
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++)
            run_instr(rand_op(), rand_wait(), rand_wait());

        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
